instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder.sv | 145 ++++++++++++++
 tb/tb_instr_encoder.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// ---------------------------------------------------------------------------
// instr_encoder
//
// Encodes simple ARMv8-style (LEGv8 subset) instruction requests into 32-bit
// instruction words and queues them in a small output FIFO.
//
// Parameters
//   DEPTH        output FIFO entries (power of two, >= 2)
//
// Ports
//   clk          single clock, all state updates on the rising edge
//   rst_n        asynchronous active-low reset
//   flush        synchronous FIFO clear (blocks push and pop that cycle)
//   in_valid     encode request present
//   in_ready     block can accept a request
//   in_op        0=B 1=AND 2=ADD 3=ORR 4=SUB 5=STUR 6=LDUR 7=illegal
//   in_rd        Rd / Rt register number
//   in_rn        Rn register number
//   in_rm        Rm register number
//   in_imm       immediate / branch offset / memory offset
//   out_valid    out_instr holds a valid instruction (FIFO not empty)
//   out_ready    consumer takes out_instr
//   out_instr    encoded word at the FIFO head (0 when empty)
//   err_illegal  one-cycle pulse after an accepted illegal op
//   fifo_count   occupied FIFO entries
//   instr_count  instructions emitted, wrapping at 16 bits
// ---------------------------------------------------------------------------
module instr_encoder #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [2:0]                 in_op,
  input  logic [4:0]                 in_rd,
  input  logic [4:0]                 in_rn,
  input  logic [4:0]                 in_rm,
  input  logic [20:0]                in_imm,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_instr,
  output logic                       err_illegal,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic [15:0]                instr_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [2:0] OP_B    = 3'd0;
  localparam logic [2:0] OP_AND  = 3'd1;
  localparam logic [2:0] OP_ADD  = 3'd2;
  localparam logic [2:0] OP_ORR  = 3'd3;
  localparam logic [2:0] OP_SUB  = 3'd4;
  localparam logic [2:0] OP_STUR = 3'd5;
  localparam logic [2:0] OP_LDUR = 3'd6;
  localparam logic [2:0] OP_ILL  = 3'd7;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          ready_en;
  logic          err_q;
  logic [15:0]   icount;
  logic [31:0]   enc_word;
  logic          accept;
  logic          push;
  logic          pop;

  // ready_en holds in_ready low during reset and rises on the first clock
  // edge after reset is released. No full-bypass: a pop in the same cycle
  // does not open a slot for a push.
  assign in_ready = ready_en && (count < CW'(DEPTH)) && !flush;
  assign accept   = in_valid && in_ready;
  assign push     = accept && (in_op != OP_ILL);

  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready && !flush;

  // Head word is forced to zero when empty so stale storage never shows.
  assign out_instr   = out_valid ? mem[rd_ptr] : 32'd0;
  assign fifo_count  = count;
  assign err_illegal = err_q;
  assign instr_count = icount;

  // Instruction encoder: opcode in [31:21], remaining fields by format.
  always_comb begin
    enc_word = 32'd0;
    case (in_op)
      OP_B:    enc_word = {11'h0B0, in_imm};
      OP_AND:  enc_word = {11'h430, in_rm, 6'd0, in_rn, in_rd};
      OP_ADD:  enc_word = {11'h258, in_rm, 6'd0, in_rn, in_rd};
      OP_ORR:  enc_word = {11'h590, in_rm, 6'd0, in_rn, in_rd};
      OP_SUB:  enc_word = {11'h124, in_rm, 6'd0, in_rn, in_rd};
      OP_STUR: enc_word = {11'h7E0, in_imm[10:0], in_rn, in_rd};
      OP_LDUR: enc_word = {11'h7A2, in_imm[10:0], in_rn, in_rd};
      default: enc_word = 32'd0;
    endcase
  end

  // FIFO storage is not reset; the occupancy count alone defines validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= enc_word;
    end
  end

  // Control state: pointers, occupancy, ready enable, error pulse, counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      ready_en <= 1'b0;
      err_q    <= 1'b0;
      icount   <= 16'd0;
    end else begin
      ready_en <= 1'b1;
      // flush forces in_ready low, so no illegal request can be accepted.
      err_q    <= accept && (in_op == OP_ILL);
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + AW'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + AW'(1);
          icount <= icount + 16'd1;
        end
        case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// ---------------------------------------------------------------------------
// tb_instr_encoder
//
// Self-checking bench for instr_encoder. Directed requests carry hand
// computed expected words; accepted legal requests push their word into a
// scoreboard queue, and an independent monitor pops and compares whenever
// the DUT hands a word to the consumer.
// ---------------------------------------------------------------------------
module tb_instr_encoder;

  localparam int DEPTH = 4;

  logic                   clk;
  logic                   rst_n;
  logic                   flush;
  logic                   in_valid;
  logic                   in_ready;
  logic [2:0]             in_op;
  logic [4:0]             in_rd;
  logic [4:0]             in_rn;
  logic [4:0]             in_rm;
  logic [20:0]            in_imm;
  logic                   out_valid;
  logic                   out_ready;
  logic [31:0]            out_instr;
  logic                   err_illegal;
  logic [$clog2(DEPTH):0] fifo_count;
  logic [15:0]            instr_count;

  int          checks;
  int          errors;
  logic [31:0] sb[$];

  instr_encoder #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_op       (in_op),
    .in_rd       (in_rd),
    .in_rn       (in_rn),
    .in_rm       (in_rm),
    .in_imm      (in_imm),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_instr   (out_instr),
    .err_illegal (err_illegal),
    .fifo_count  (fifo_count),
    .instr_count (instr_count)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t",
               name, actual, expected, $time);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request for one edge; check in_ready against the expected
  // acceptance and queue the expected word if it is a legal accepted op.
  task automatic applyStimulus(input logic [2:0] op, input logic [4:0] rd,
                               input logic [4:0] rn, input logic [4:0] rm,
                               input logic [20:0] imm, input logic accept,
                               input logic [31:0] word);
    in_valid = 1'b1;
    in_op    = op;
    in_rd    = rd;
    in_rn    = rn;
    in_rm    = rm;
    in_imm   = imm;
    #1;
    checkOutput("in_ready", {31'd0, in_ready}, {31'd0, accept});
    if (accept && op != 3'd7) sb.push_back(word);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Bounded wait for the FIFO to drain.
  task automatic waitEmpty(input int budget);
    int n;
    n = 0;
    while (fifo_count != '0 && n < budget) begin
      tick();
      n++;
    end
    checkOutput("drain_timeout", 32'(fifo_count), 32'd0);
  endtask

  // Monitor: sampled on the falling edge, a handshake seen here is the
  // emit that happens on the following rising edge.
  initial begin
    logic [31:0] exp_word;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready && !flush) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_output: got 0x%08h, expected none at %0t",
                   out_instr, $time);
        end else begin
          exp_word = sb.pop_front();
          checkOutput("sb_word", out_instr, exp_word);
        end
      end
    end
  end

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_op     = 3'd0;
    in_rd     = 5'd0;
    in_rn     = 5'd0;
    in_rm     = 5'd0;
    in_imm    = 21'd0;
    out_ready = 1'b0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd0);
    checkOutput("rst_fifo_count", 32'(fifo_count), 32'd0);
    checkOutput("rst_instr_count", 32'(instr_count), 32'd0);
    checkOutput("rst_err", {31'd0, err_illegal}, 32'd0);
    rst_n = 1'b1;
    #1;
    checkOutput("in_ready_before_edge", {31'd0, in_ready}, 32'd0);
    tick();
    checkOutput("in_ready_after_edge", {31'd0, in_ready}, 32'd1);

    // ADD with one-cycle latency.
    out_ready = 1'b1;
    applyStimulus(3'd2, 5'd3, 5'd1, 5'd2, 21'd0, 1'b1, 32'h4B020023);
    checkOutput("add_out_valid", {31'd0, out_valid}, 32'd1);
    checkOutput("add_out_instr", out_instr, 32'h4B020023);
    checkOutput("add_count", 32'(fifo_count), 32'd1);
    tick();
    checkOutput("add_instr_count", 32'(instr_count), 32'd1);
    checkOutput("empty_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("empty_out_instr", out_instr, 32'd0);

    // D-type, branch and R-type with a full-width immediate.
    applyStimulus(3'd6, 5'd5, 5'd2, 5'd9, 21'h1FF808, 1'b1, 32'hF4402045);
    tick();
    applyStimulus(3'd5, 5'd5, 5'd2, 5'd31, 21'd8, 1'b1, 32'hFC002045);
    tick();
    applyStimulus(3'd0, 5'd7, 5'd7, 5'd7, 21'h1FFFFF, 1'b1, 32'h161FFFFF);
    checkOutput("b_word", out_instr, 32'h161FFFFF);
    tick();
    applyStimulus(3'd3, 5'd1, 5'd2, 5'd3, 21'h1FFFFF, 1'b1, 32'hB2030041);
    checkOutput("rtype_bits_15_10", {26'd0, out_instr[15:10]}, 32'd0);
    tick();
    checkOutput("instr_count_5", 32'(instr_count), 32'd5);

    // Backpressure: five requests, four fit.
    out_ready = 1'b0;
    applyStimulus(3'd4, 5'd4, 5'd5, 5'd6, 21'd0, 1'b1, 32'h248600A4);
    applyStimulus(3'd1, 5'd7, 5'd8, 5'd9, 21'd0, 1'b1, 32'h86090107);
    applyStimulus(3'd2, 5'd10, 5'd11, 5'd12, 21'd0, 1'b1, 32'h4B0C016A);
    applyStimulus(3'd3, 5'd13, 5'd14, 5'd15, 21'd0, 1'b1, 32'hB20F01CD);
    applyStimulus(3'd2, 5'd1, 5'd1, 5'd1, 21'd0, 1'b0, 32'h4B010021);
    checkOutput("full_count", 32'(fifo_count), 32'd4);
    tick();
    checkOutput("hold_head_1", out_instr, 32'h248600A4);
    tick();
    checkOutput("hold_head_2", out_instr, 32'h248600A4);
    out_ready = 1'b1;
    tick();
    checkOutput("pop_count", 32'(fifo_count), 32'd3);
    applyStimulus(3'd6, 5'd5, 5'd2, 5'd0, 21'd8, 1'b1, 32'hF4402045);
    checkOutput("push_pop_count", 32'(fifo_count), 32'd3);
    waitEmpty(20);
    checkOutput("instr_count_10", 32'(instr_count), 32'd10);

    // Illegal op.
    applyStimulus(3'd7, 5'd1, 5'd1, 5'd1, 21'd0, 1'b1, 32'd0);
    checkOutput("err_pulse", {31'd0, err_illegal}, 32'd1);
    checkOutput("ill_count", 32'(fifo_count), 32'd0);
    checkOutput("ill_out_valid", {31'd0, out_valid}, 32'd0);
    tick();
    checkOutput("err_one_cycle", {31'd0, err_illegal}, 32'd0);
    applyStimulus(3'd2, 5'd3, 5'd1, 5'd2, 21'd0, 1'b1, 32'h4B020023);
    tick();
    checkOutput("instr_count_11", 32'(instr_count), 32'd11);

    // Flush together with an illegal request.
    flush    = 1'b1;
    in_valid = 1'b1;
    in_op    = 3'd7;
    #1;
    checkOutput("flush_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    checkOutput("flush_no_err", {31'd0, err_illegal}, 32'd0);

    // Flush with three entries queued.
    out_ready = 1'b0;
    applyStimulus(3'd1, 5'd7, 5'd8, 5'd9, 21'd0, 1'b1, 32'h86090107);
    applyStimulus(3'd4, 5'd4, 5'd5, 5'd6, 21'd0, 1'b1, 32'h248600A4);
    applyStimulus(3'd0, 5'd0, 5'd0, 5'd0, 21'd5, 1'b1, 32'h16000005);
    checkOutput("pre_flush_count", 32'(fifo_count), 32'd3);
    flush = 1'b1;
    sb.delete();
    tick();
    flush = 1'b0;
    checkOutput("flush_count", 32'(fifo_count), 32'd0);
    checkOutput("flush_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("flush_out_instr", out_instr, 32'd0);
    checkOutput("flush_instr_count", 32'(instr_count), 32'd11);

    // Asynchronous reset mid-stream.
    applyStimulus(3'd1, 5'd7, 5'd8, 5'd9, 21'd0, 1'b1, 32'h86090107);
    applyStimulus(3'd4, 5'd4, 5'd5, 5'd6, 21'd0, 1'b1, 32'h248600A4);
    #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    checkOutput("arst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("arst_out_instr", out_instr, 32'd0);
    checkOutput("arst_count", 32'(fifo_count), 32'd0);
    checkOutput("arst_instr_count", 32'(instr_count), 32'd0);
    checkOutput("arst_in_ready", {31'd0, in_ready}, 32'd0);
    checkOutput("arst_err", {31'd0, err_illegal}, 32'd0);
    #2;
    rst_n = 1'b1;
    tick();
    checkOutput("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;
    applyStimulus(3'd2, 5'd3, 5'd1, 5'd2, 21'd0, 1'b1, 32'h4B020023);
    tick();
    checkOutput("post_rst_instr_count", 32'(instr_count), 32'd1);
    waitEmpty(20);
    tick();
    checkOutput("sb_leftover", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
